// File: rtl/leb128_stream_unpack.sv
// ---------------------------------------------------------------------------
// leb128_stream_unpack
//
// Streaming LEB128 decoder. Encoded bytes arrive over a valid/ready handshake
// and are collected one value at a time into a byte window (first byte in the
// MSBs). Once a terminator byte (bit7 = 0) or MAXB bytes have been taken, the
// decoded value is held on an output valid/ready handshake until accepted.
// Fill and emit never overlap.
//
// Parameters:
//   N      : decoded value width, 32 or 64. MAXB = ceil(N/7) bytes.
//   SIGNED : 1 = sign-extended result, 0 = zero-extended result.
//
// Ports:
//   clk       : clock, all state changes on the rising edge.
//   rstn      : synchronous active-low reset.
//   in_data   : encoded byte.
//   in_valid  : in_data is valid.
//   in_ready  : block accepts in_data this cycle.
//   out_data  : decoded value (0 when out_valid = 0 or on error).
//   out_len   : number of bytes consumed, 1..MAXB.
//   out_err   : overlong encoding, no terminator within MAXB bytes.
//   out_valid : out_data/out_len/out_err are valid.
//   out_ready : consumer accepts the output.
//
// Also contains the window decoders unpack_unsigned / unpack_signed and
// their shared core leb128_window_decode.
// ---------------------------------------------------------------------------

// Shared core: finds the first terminator in the window and returns the
// concatenated 7-bit payload groups up to and including it (zeros above).
// With no terminator the whole window is used and len = MAXB.
module leb128_window_decode #(
    parameter int MAXB = 10
) (
    input  logic [8*MAXB-1:0] window,
    output logic [7*MAXB-1:0] raw,
    output logic [3:0]        len
);
    localparam int W = 7 * MAXB;

    logic [W-1:0]    payload;
    logic [MAXB-1:0] term;
    int              nbytes;

    generate
        for (genvar gi = 0; gi < MAXB; gi++) begin : g_byte
            assign payload[7*gi +: 7] = window[8*MAXB-2-8*gi -: 7];
            assign term[gi]           = ~window[8*MAXB-1-8*gi];
        end
    endgenerate

    always_comb begin
        nbytes = MAXB;
        // Scan from the top so the lowest-numbered terminator wins.
        for (int i = MAXB - 1; i >= 0; i--) begin
            if (term[i]) begin
                nbytes = i + 1;
            end
        end
        raw = '0;
        for (int j = 0; j < W; j++) begin
            if (j < 7 * nbytes) begin
                raw[j] = payload[j];
            end
        end
        len = 4'(nbytes);
    end
endmodule

// Zero-extended decode; payload bits above N are dropped.
module unpack_unsigned #(
    parameter int N = 64
) (
    input  logic [8*((N+6)/7)-1:0] window,
    output logic [N-1:0]           value,
    output logic [3:0]             len
);
    localparam int MAXB = (N + 6) / 7;
    localparam int W    = 7 * MAXB;

    logic [W-1:0] raw;
    logic         unused_hi;

    leb128_window_decode #(.MAXB(MAXB)) u_core (
        .window (window),
        .raw    (raw),
        .len    (len)
    );

    assign value     = raw[N-1:0];
    assign unused_hi = ^raw[W-1:N];
endmodule

// Sign-extended decode: bit 6 of the terminating byte is the sign.
module unpack_signed #(
    parameter int N = 64
) (
    input  logic [8*((N+6)/7)-1:0] window,
    output logic [N-1:0]           value,
    output logic [3:0]             len
);
    localparam int MAXB = (N + 6) / 7;
    localparam int W    = 7 * MAXB;

    logic [W-1:0] raw;
    logic         sign;
    logic         unused_hi;

    leb128_window_decode #(.MAXB(MAXB)) u_core (
        .window (window),
        .raw    (raw),
        .len    (len)
    );

    always_comb begin
        sign = 1'b0;
        for (int i = 0; i < MAXB; i++) begin
            if (int'(len) == i + 1) begin
                sign = raw[7*i+6];
            end
        end
        value = '0;
        for (int j = 0; j < N; j++) begin
            value[j] = (j < 7 * int'(len)) ? raw[j] : sign;
        end
    end

    assign unused_hi = ^raw[W-1:N];
endmodule

module leb128_stream_unpack #(
    parameter int N      = 64,
    parameter bit SIGNED = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic [3:0]   out_len,
    output logic         out_err,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int MAXB = (N + 6) / 7;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg;
    logic [8*MAXB-1:0]   window_reg;
    logic                err_reg;
    // Holds in_ready low until the first edge with rstn released.
    logic                run_reg;

    logic [N-1:0]        dec_value;
    logic [3:0]          dec_len;
    logic                accept;
    logic                last_byte;

    generate
        if (SIGNED) begin : g_signed
            unpack_signed #(.N(N)) u_dec (
                .window (window_reg),
                .value  (dec_value),
                .len    (dec_len)
            );
        end else begin : g_unsigned
            unpack_unsigned #(.N(N)) u_dec (
                .window (window_reg),
                .value  (dec_value),
                .len    (dec_len)
            );
        end
    endgenerate

    assign in_ready  = rstn && run_reg && (state_reg == FILL);
    assign accept    = in_valid && in_ready;
    assign last_byte = (cnt_reg == 4'(MAXB - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: begin
                if (accept && (!in_data[7] || last_byte)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= FILL;
            cnt_reg    <= 4'd0;
            window_reg <= '0;
            err_reg    <= 1'b0;
            run_reg    <= 1'b0;
        end else begin
            run_reg   <= 1'b1;
            state_reg <= state_next;
            if (accept) begin
                for (int i = 0; i < MAXB; i++) begin
                    if (cnt_reg == 4'(i)) begin
                        window_reg[8*MAXB-1-8*i -: 8] <= in_data;
                    end
                end
                cnt_reg <= cnt_reg + 4'd1;
                // Error only if the MAXB-th byte still has its continuation bit.
                err_reg <= in_data[7] && last_byte;
            end else if ((state_reg == EMIT) && out_ready) begin
                window_reg <= '0;
                cnt_reg    <= 4'd0;
                err_reg    <= 1'b0;
            end
        end
    end

    assign out_valid = (state_reg == EMIT);
    assign out_err   = out_valid && err_reg;
    assign out_data  = (out_valid && !err_reg) ? dec_value : '0;
    assign out_len   = !out_valid ? 4'd0 : (err_reg ? 4'(MAXB) : dec_len);
endmodule

// File: tb/tb_leb128_stream_unpack.sv
// ---------------------------------------------------------------------------
// tb_leb128_stream_unpack
//
// Drives two instances: N=64 signed (sel 0) and N=32 unsigned (sel 1).
// Fixed vectors from a table, a few hand-written corner sequences, then
// random values checked against an arithmetic LEB128 model.
// ---------------------------------------------------------------------------
module tb_leb128_stream_unpack;
    logic        clk = 1'b0;
    logic        rstn;

    logic [7:0]  in_data64,  in_data32;
    logic        in_valid64, in_valid32;
    logic        in_ready64, in_ready32;
    logic [63:0] out_data64;
    logic [31:0] out_data32;
    logic [3:0]  out_len64,  out_len32;
    logic        out_err64,  out_err32;
    logic        out_valid64, out_valid32;
    logic        out_ready64, out_ready32;

    int tests = 0;
    int fails = 0;

    logic [7:0] stim [10];

    always #5 clk = ~clk;

    leb128_stream_unpack #(.N(64), .SIGNED(1'b1)) dut64 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data64),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .out_data  (out_data64),
        .out_len   (out_len64),
        .out_err   (out_err64),
        .out_valid (out_valid64),
        .out_ready (out_ready64)
    );

    leb128_stream_unpack #(.N(32), .SIGNED(1'b0)) dut32 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data32),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .out_data  (out_data32),
        .out_len   (out_len32),
        .out_err   (out_err32),
        .out_valid (out_valid32),
        .out_ready (out_ready32)
    );

    typedef struct {
        int          sel;
        int          nb;
        logic [79:0] bytes;   // first byte in the MSBs
        logic [63:0] d;
        logic [3:0]  l;
        bit          e;
        int          hold;
    } vec_t;

    vec_t tab [12];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin in_valid64 = v; in_data64 = d; end
        else          begin in_valid32 = v; in_data32 = d; end
    endtask

    task automatic set_oready(input int sel, input logic v);
        if (sel == 0) out_ready64 = v; else out_ready32 = v;
    endtask

    function automatic logic g_iready(input int sel);
        return (sel == 0) ? in_ready64 : in_ready32;
    endfunction
    function automatic logic g_ovalid(input int sel);
        return (sel == 0) ? out_valid64 : out_valid32;
    endfunction
    function automatic logic [63:0] g_odata(input int sel);
        return (sel == 0) ? out_data64 : {32'd0, out_data32};
    endfunction
    function automatic logic [3:0] g_olen(input int sel);
        return (sel == 0) ? out_len64 : out_len32;
    endfunction
    function automatic logic g_oerr(input int sel);
        return (sel == 0) ? out_err64 : out_err32;
    endfunction

    // Reference: value = sum of 7-bit groups << 7*i up to the first byte with
    // bit7 clear, sign-extended from the top group bit when signed, then
    // truncated to n bits. No terminator in ceil(n/7) bytes -> error.
    function automatic void model(input int n, input bit sgn, output logic [63:0] v,
                                  output logic [3:0] l, output bit e);
        int           maxb = (n + 6) / 7;
        int           len = 0;
        logic [127:0] acc = '0;
        for (int i = 0; i < maxb; i++) begin
            acc = acc | (128'(stim[i] & 8'h7f) << (7 * i));
            if (stim[i][7] == 1'b0) begin
                len = i + 1;
                break;
            end
        end
        if (len == 0) begin
            v = '0; l = 4'(maxb); e = 1'b1;
        end else begin
            if (sgn && (((acc >> (7 * len - 1)) & 128'd1) != 128'd0))
                acc = acc | ~((128'd1 << (7 * len)) - 128'd1);
            v = (n == 64) ? acc[63:0] : {32'd0, acc[31:0]};
            l = 4'(len);
            e = 1'b0;
        end
    endfunction

    // Feed stim[0..nb-1], then check the emitted result, hold it under
    // backpressure for 'hold' cycles, and release it.
    task automatic run_txn(input int sel, input int nb, input logic [63:0] exp_d,
                           input logic [3:0] exp_l, input bit exp_e, input int hold,
                           input string nm);
        int guard;
        for (int k = 0; k < nb; k++) begin
            set_in(sel, 1'b1, stim[k]);
            guard = 0;
            while (!g_iready(sel) && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 50) chk({nm, "_in_ready_timeout"}, 64'(g_iready(sel)), 64'd1);
            @(posedge clk); #1;
            if (k < nb - 1 && $urandom_range(0, 3) == 0) begin
                set_in(sel, 1'b0, 8'($urandom));
                @(posedge clk); #1;
            end
        end
        set_in(sel, 1'b0, 8'h00);
        chk({nm, "_valid"}, 64'(g_ovalid(sel)), 64'd1);
        chk({nm, "_data"},  g_odata(sel),       exp_d);
        chk({nm, "_len"},   64'(g_olen(sel)),   64'(exp_l));
        chk({nm, "_err"},   64'(g_oerr(sel)),   64'(exp_e));
        for (int h = 0; h < hold; h++) begin
            set_in(sel, 1'b1, 8'($urandom));
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 64'(g_ovalid(sel)),  64'd1);
            chk({nm, "_hold_data"},  g_odata(sel),        exp_d);
            chk({nm, "_hold_ready"}, 64'(g_iready(sel)),  64'd0);
        end
        set_in(sel, 1'b0, 8'h00);
        set_oready(sel, 1'b1);
        @(posedge clk); #1;
        set_oready(sel, 1'b0);
        chk({nm, "_done_valid"}, 64'(g_ovalid(sel)), 64'd0);
        chk({nm, "_done_data"},  g_odata(sel),       64'd0);
        chk({nm, "_done_ready"}, 64'(g_iready(sel)), 64'd1);
        $display("[TB] %s sel=%0d bytes=%0d data=%h len=%0d err=%0d", nm, sel, nb, exp_d, exp_l, exp_e);
    endtask

    task automatic load_stim(input logic [79:0] b);
        for (int k = 0; k < 10; k++) stim[k] = b[79 - 8*k -: 8];
    endtask

    task automatic gen_random(input int n, output int nb);
        int maxb = (n + 6) / 7;
        for (int k = 0; k < 10; k++) stim[k] = 8'h00;
        if ($urandom_range(0, 7) == 0) begin
            nb = maxb;
            for (int k = 0; k < nb; k++) stim[k] = 8'h80 | 8'($urandom_range(0, 127));
        end else begin
            nb = $urandom_range(1, maxb);
            for (int k = 0; k < nb - 1; k++) stim[k] = 8'h80 | 8'($urandom_range(0, 127));
            stim[nb-1] = 8'($urandom_range(0, 127));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ev;
        logic [3:0]  el;
        bit          ee;
        int          nb;

        rstn = 1'b0;
        in_data64 = 8'h00; in_valid64 = 1'b0; out_ready64 = 1'b0;
        in_data32 = 8'h00; in_valid32 = 1'b0; out_ready32 = 1'b0;

        tab[0]  = '{0, 1,  80'h01000000000000000000, 64'h1,                  4'd1,  1'b0, 0};
        tab[1]  = '{0, 10, 80'hffffffffffffffffff01, 64'hffffffffffffffff,   4'd10, 1'b0, 0};
        tab[2]  = '{0, 5,  80'h808080800c0000000000, 64'h00000000c0000000,   4'd5,  1'b0, 1};
        tab[3]  = '{0, 10, 80'h8080808080808080c001, 64'hc000000000000000,   4'd10, 1'b0, 0};
        tab[4]  = '{0, 10, 80'h80808080808080808080, 64'h0,                  4'd10, 1'b1, 0};
        tab[5]  = '{0, 1,  80'h05000000000000000000, 64'h5,                  4'd1,  1'b0, 0};
        tab[6]  = '{0, 1,  80'h7f000000000000000000, 64'hffffffffffffffff,   4'd1,  1'b0, 3};
        tab[7]  = '{0, 1,  80'h40000000000000000000, 64'hffffffffffffffc0,   4'd1,  1'b0, 0};
        tab[8]  = '{0, 2,  80'hc0000000000000000000, 64'h40,                 4'd2,  1'b0, 0};
        tab[9]  = '{1, 5,  80'h808080800c0000000000, 64'h00000000c0000000,   4'd5,  1'b0, 0};
        tab[10] = '{1, 5,  80'h80808080800000000000, 64'h0,                  4'd5,  1'b1, 2};
        tab[11] = '{1, 1,  80'h7f000000000000000000, 64'h7f,                 4'd1,  1'b0, 0};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid64", 64'(out_valid64), 64'd0);
        chk("rst_data64",  out_data64,       64'd0);
        chk("rst_len64",   64'(out_len64),   64'd0);
        chk("rst_err64",   64'(out_err64),   64'd0);
        chk("rst_ready64", 64'(in_ready64),  64'd0);
        chk("rst_valid32", 64'(out_valid32), 64'd0);
        chk("rst_ready32", 64'(in_ready32),  64'd0);
        rstn = 1'b1;
        #1;
        chk("rel_ready64_pre", 64'(in_ready64), 64'd0);
        @(posedge clk); #1;
        chk("rel_ready64", 64'(in_ready64), 64'd1);
        chk("rel_ready32", 64'(in_ready32), 64'd1);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            load_stim(tab[i].bytes);
            run_txn(tab[i].sel, tab[i].nb, tab[i].d, tab[i].l, tab[i].e, tab[i].hold,
                    $sformatf("vec%0d", i));
        end

        // Reset mid-fill: partial 80 80 80 must vanish without an output
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1'b1, 8'h80);
            @(posedge clk); #1;
        end
        set_in(0, 1'b0, 8'h00);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", 64'(in_ready64),  64'd0);
        chk("midrst_valid", 64'(out_valid64), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("midrst_post_valid", 64'(out_valid64), 64'd0);
        load_stim(80'h05000000000000000000);
        run_txn(0, 1, 64'h5, 4'd1, 1'b0, 0, "midrst_05");

        // Reset while a result is pending
        load_stim(80'h2a000000000000000000);
        set_in(0, 1'b1, 8'h2a);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00);
        chk("emitrst_pre_valid", 64'(out_valid64), 64'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("emitrst_valid", 64'(out_valid64), 64'd0);
        @(posedge clk); #1;

        // Random values against the reference model
        for (int r = 0; r < 60; r++) begin
            gen_random(64, nb);
            model(64, 1'b1, ev, el, ee);
            run_txn(0, nb, ev, el, ee, $urandom_range(0, 2), $sformatf("rnd64_%0d", r));
        end
        for (int r = 0; r < 30; r++) begin
            gen_random(32, nb);
            model(32, 1'b0, ev, el, ee);
            run_txn(1, nb, ev, el, ee, $urandom_range(0, 2), $sformatf("rnd32_%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/leb128_stream_unpack.md
Name: leb128_stream_unpack

Overview:
- Streaming LEB128 decoder controller. Accepts an encoded byte stream over a valid/ready handshake and assembles one encoded value at a time into a byte window.
- Drives `unpack_signed` or `unpack_unsigned` (per `SIGNED`) on that window and presents the decoded value, byte length and an overlong-error flag on an output valid/ready handshake.
- Sits between a byte-oriented parser front end and consumers of decoded integers.

Parameters:
- N, 64, decoded value width; 32 or 64 only. MAXB = ceil(N/7): 5 for N=32, 10 for N=64.
- SIGNED, 1, 1 instantiates `unpack_signed` (sign-extended result); 0 instantiates `unpack_unsigned`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- in_data  in  8  encoded byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  N  decoded value.
- out_len  out  4  number of bytes consumed, 1..MAXB.
- out_err  out  1  overlong encoding: no terminator within MAXB bytes.
- out_valid  out  1  out_data, out_len and out_err are valid.
- out_ready  in  1  consumer accepts the output.

Behaviour:
- Reset (rstn=0 at an edge):
  - state=FILL; byte count cnt=0; window cleared to 0.
  - out_valid=0, out_data=0, out_len=0, out_err=0.
  - in_ready=0 while rstn is low, 1 after the first edge with rstn high.
  - Reset mid-fill or mid-emit discards all partial and pending data with no output.
- Window:
  - Width 8*MAXB bits. The k-th accepted byte (k=0..MAXB-1) is written to bits [8*MAXB-1-8k -: 8], so the first byte is in the MSBs.
  - Unwritten bytes stay 0. The decoder ignores bytes past the terminator.
  - The decoder is purely combinational on the window register.
- States:
  - FILL:
    - in_ready=1, out_valid=0.
    - On in_valid & in_ready, store the byte at position cnt and set cnt=cnt+1.
    - If the byte has bit7=0 (terminator): next state EMIT, err=0.
    - Else if cnt+1==MAXB: next state EMIT, err=1.
    - Else remain in FILL.
  - EMIT:
    - in_ready=0, out_valid=1.
    - out_data = decoder value, out_len = decoder length.
    - When err=1: out_data=0 and out_len=MAXB.
    - Outputs are stable while out_ready=0 (backpressure can last indefinitely).
    - On out_valid & out_ready: clear the window, cnt=0, err=0, next state FILL.
- Outputs are forced to 0 whenever out_valid=0.
- Latency and throughput:
  - out_valid rises on the cycle after the terminating (or MAXB-th) byte is accepted.
  - An L-byte value occupies L+1 cycles minimum. There is no overlap of fill and emit.
- Terminator on byte MAXB: valid, not an error. Excess high bits in that byte are ignored, as the decoder does.
- in_data is ignored when in_valid=0 or in_ready=0. out_ready is ignored in FILL.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- N=64, SIGNED=1:
  - Reset, then byte 0x01 → one cycle later out_valid=1, out_data=1, out_len=1, out_err=0. Hold out_ready=1 → back in FILL the next cycle, in_ready=1.
  - Bytes ff×9 then 01 → out_data=64'hffffffffffffffff (−1), out_len=10, out_err=0.
  - Bytes 80 80 80 80 0c → out_data=64'h00000000c0000000, out_len=5.
  - Bytes 80×8 c0 01 → out_data=64'hc000000000000000, out_len=10.
  - Ten bytes 0x80 → out_err=1, out_data=0, out_len=10. The next byte 0x05 decodes to 5, len 1.
- Backpressure: after byte 0x7f (signed → −1, len 1), hold out_ready=0 for 3 cycles → out_valid stays 1 with a stable value and in_ready=0; in_data toggling with in_valid=1 is not consumed.
- Reset mid-fill: send 80 80 80, pull rstn low for one edge, then send 05 → single output 5, len 1; no output for the partial value.
- N=32, SIGNED=0: bytes 80 80 80 80 0c → out_data=32'hc0000000, len 5. Five bytes 0x80 → out_err=1, out_len=5.
